// File: rtl/m_div_ctrl.sv
// m_div_ctrl: issue/control stage for the RV32M divide path.
// Resolves div-by-zero, signed overflow and repeated operands locally.
module m_div_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            STALL,
    input  logic            VALID_IN,
    input  logic [1:0]      OP,
    input  logic [XLEN-1:0] RS1,
    input  logic [XLEN-1:0] RS2,
    output logic            BUSY,
    output logic            RESULT_VALID,
    output logic [XLEN-1:0] RESULT,
    output logic            DIV_START,
    output logic            DIV_SIGN,
    output logic            DIV_STALL,
    output logic [XLEN-1:0] DIV_DIVIDEND,
    output logic [XLEN-1:0] DIV_DIVIDER,
    input  logic [XLEN-1:0] DIV_QUOTIENT,
    input  logic [XLEN-1:0] DIV_REMAINDER,
    input  logic            DIV_READY
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state;
    logic            sel_rem;
    logic [XLEN-1:0] req_rs1;
    logic [XLEN-1:0] req_rs2;
    logic            req_sgn;
    logic            negq;
    logic            negr;

    logic            cache_vld;
    logic [XLEN-1:0] cache_rs1;
    logic [XLEN-1:0] cache_rs2;
    logic            cache_sgn;
    logic [XLEN-1:0] cache_q;
    logic [XLEN-1:0] cache_r;

    logic            accept;
    logic            sgn_in;
    logic            div0;
    logic            ovf;
    logic            hit;
    logic [XLEN-1:0] mag1;
    logic [XLEN-1:0] mag2;
    logic [XLEN-1:0] qfix;
    logic [XLEN-1:0] rfix;

    // The divider always runs unsigned and never stalls.
    assign DIV_SIGN  = 1'b0;
    assign DIV_STALL = 1'b0;

    // Request classification and sign correction of divider outputs.
    always_comb begin
        accept = (state == S_IDLE) && VALID_IN && !STALL;
        sgn_in = !OP[0];
        div0   = (RS2 == '0);
        ovf    = sgn_in && (RS1 == INT_MIN) && (RS2 == '1);
        hit    = cache_vld && (RS1 == cache_rs1) && (RS2 == cache_rs2)
                 && (sgn_in == cache_sgn);
        mag1   = (sgn_in && RS1[XLEN-1]) ? -RS1 : RS1;
        mag2   = (sgn_in && RS2[XLEN-1]) ? -RS2 : RS2;
        qfix   = negq ? -DIV_QUOTIENT : DIV_QUOTIENT;
        rfix   = negr ? -DIV_REMAINDER : DIV_REMAINDER;
    end

    // Control FSM with registered outputs and the single-entry result cache.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state        <= S_IDLE;
            BUSY         <= 1'b0;
            RESULT_VALID <= 1'b0;
            RESULT       <= '0;
            DIV_START    <= 1'b0;
            DIV_DIVIDEND <= '0;
            DIV_DIVIDER  <= '0;
            sel_rem      <= 1'b0;
            req_rs1      <= '0;
            req_rs2      <= '0;
            req_sgn      <= 1'b0;
            negq         <= 1'b0;
            negr         <= 1'b0;
            cache_vld    <= 1'b0;
            cache_rs1    <= '0;
            cache_rs2    <= '0;
            cache_sgn    <= 1'b0;
            cache_q      <= '0;
            cache_r      <= '0;
        end else begin
            DIV_START <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        sel_rem <= OP[1];
                        req_rs1 <= RS1;
                        req_rs2 <= RS2;
                        req_sgn <= sgn_in;
                        if (div0) begin
                            state        <= S_DONE;
                            RESULT_VALID <= 1'b1;
                            RESULT       <= OP[1] ? RS1 : '1;
                        end else if (ovf) begin
                            state        <= S_DONE;
                            RESULT_VALID <= 1'b1;
                            RESULT       <= OP[1] ? '0 : RS1;
                        end else if (hit) begin
                            state        <= S_DONE;
                            RESULT_VALID <= 1'b1;
                            RESULT       <= OP[1] ? cache_r : cache_q;
                        end else begin
                            state        <= S_ISSUE;
                            BUSY         <= 1'b1;
                            DIV_START    <= 1'b1;
                            DIV_DIVIDEND <= mag1;
                            DIV_DIVIDER  <= mag2;
                            negq <= sgn_in & (RS1[XLEN-1] ^ RS2[XLEN-1]);
                            negr <= sgn_in & RS1[XLEN-1];
                        end
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (DIV_READY) begin
                        state        <= S_DONE;
                        BUSY         <= 1'b0;
                        RESULT_VALID <= 1'b1;
                        RESULT       <= sel_rem ? rfix : qfix;
                        cache_vld    <= 1'b1;
                        cache_rs1    <= req_rs1;
                        cache_rs2    <= req_rs2;
                        cache_sgn    <= req_sgn;
                        cache_q      <= qfix;
                        cache_r      <= rfix;
                    end
                end
                S_DONE: begin
                    if (!STALL) begin
                        state        <= S_IDLE;
                        RESULT_VALID <= 1'b0;
                        RESULT       <= '0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m_div_ctrl.sv
// tb_m_div_ctrl: scoreboard bench for m_div_ctrl with a behavioural
// unsigned divider stub (READY high XLEN edges after START is sampled).
module tb_m_div_ctrl;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        STALL = 1'b0;
    logic        VALID_IN = 1'b0;
    logic [1:0]  OP = 2'b00;
    logic [31:0] RS1 = '0;
    logic [31:0] RS2 = '0;
    logic        BUSY;
    logic        RESULT_VALID;
    logic [31:0] RESULT;
    logic        DIV_START;
    logic        DIV_SIGN;
    logic        DIV_STALL;
    logic [31:0] DIV_DIVIDEND;
    logic [31:0] DIV_DIVIDER;
    logic [31:0] DIV_QUOTIENT = '0;
    logic [31:0] DIV_REMAINDER = '0;
    logic        DIV_READY = 1'b1;
    int          dcnt = 0;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    logic        prev_rv = 1'b0;
    int          n_res = 0;

    m_div_ctrl #(.XLEN(32)) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .STALL(STALL),
        .VALID_IN(VALID_IN),
        .OP(OP),
        .RS1(RS1),
        .RS2(RS2),
        .BUSY(BUSY),
        .RESULT_VALID(RESULT_VALID),
        .RESULT(RESULT),
        .DIV_START(DIV_START),
        .DIV_SIGN(DIV_SIGN),
        .DIV_STALL(DIV_STALL),
        .DIV_DIVIDEND(DIV_DIVIDEND),
        .DIV_DIVIDER(DIV_DIVIDER),
        .DIV_QUOTIENT(DIV_QUOTIENT),
        .DIV_REMAINDER(DIV_REMAINDER),
        .DIV_READY(DIV_READY)
    );

    always #5 CLK = ~CLK;

    // Divider stub: drops READY on the START edge, raises it 32 edges later.
    always @(posedge CLK) begin
        if (DIV_START) begin
            DIV_QUOTIENT  <= DIV_DIVIDEND / DIV_DIVIDER;
            DIV_REMAINDER <= DIV_DIVIDEND % DIV_DIVIDER;
            DIV_READY     <= 1'b0;
            dcnt          <= 32;
        end else if (dcnt > 0) begin
            dcnt <= dcnt - 1;
            if (dcnt == 1) DIV_READY <= 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: each rising RESULT_VALID pops one expected result.
    always @(negedge CLK) begin
        if (RESULT_VALID === 1'b1 && !prev_rv) begin
            n_res++;
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_unexpected: got %h, expected none", RESULT);
            end else begin
                chk($sformatf("sb_result_%0d", n_res), RESULT,
                    exp_q.pop_front());
            end
        end
        prev_rv <= (RESULT_VALID === 1'b1);
    end

    // Issue one request, hold it until RESULT_VALID, check timing.
    // exp_k: edges after the accept edge before RESULT_VALID is seen.
    task automatic do_req(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp,
                          input int exp_k, input bit hold);
        int k;
        int busy;
        int starts;
        exp_q.push_back(exp);
        OP = op;
        RS1 = a;
        RS2 = b;
        VALID_IN = 1'b1;
        @(posedge CLK);
        #1;
        k = 0;
        busy = 0;
        starts = 0;
        while (RESULT_VALID !== 1'b1 && k < 100) begin
            if (BUSY === 1'b1) busy++;
            if (DIV_START === 1'b1) starts++;
            @(posedge CLK);
            #1;
            k++;
        end
        chk("latency", k, exp_k);
        chk("busy_cycles", busy, exp_k);
        chk("start_pulses", starts, (exp_k != 0) ? 1 : 0);
        VALID_IN = 1'b0;
        if (hold) begin
            STALL = 1'b1;
            for (int i = 0; i < 5; i++) begin
                @(posedge CLK);
                #1;
                chk("stall_valid", RESULT_VALID, 1'b1);
                chk("stall_result", RESULT, exp);
                chk("stall_busy", BUSY, 1'b0);
                if (i == 1) begin
                    OP = 2'b01;
                    RS1 = 32'd9;
                    RS2 = 32'd3;
                    VALID_IN = 1'b1;
                end
                if (i == 2) VALID_IN = 1'b0;
            end
            STALL = 1'b0;
        end
        @(posedge CLK);
        #1;
        chk("done_to_idle", RESULT_VALID, 1'b0);
        if (hold) begin
            @(posedge CLK);
            #1;
            chk("pulse_ignored", BUSY, 1'b0);
        end
    endtask

    initial begin
        #2;
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_valid", RESULT_VALID, 1'b0);
        chk("rst_result", RESULT, 32'h0);
        chk("rst_start", DIV_START, 1'b0);
        chk("rst_dividend", DIV_DIVIDEND, 32'h0);
        chk("div_sign", DIV_SIGN, 1'b0);
        chk("div_stall", DIV_STALL, 1'b0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;

        // Signed divide through the divider, then a cache hit for REM.
        do_req(2'b00, 32'h00000014, 32'hFFFFFFFD, 32'hFFFFFFFA, 34, 0);
        do_req(2'b10, 32'h00000014, 32'hFFFFFFFD, 32'h00000002, 0, 0);
        // Remainder sign follows the dividend.
        do_req(2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 34, 0);
        do_req(2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 34, 0);
        do_req(2'b01, 32'd100, 32'd7, 32'd14, 34, 0);
        // Divide by zero.
        do_req(2'b01, 32'd5, 32'd0, 32'hFFFFFFFF, 0, 0);
        do_req(2'b11, 32'd5, 32'd0, 32'd5, 0, 0);
        // Signed overflow, then the unsigned form uses the divider.
        do_req(2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 0);
        do_req(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 0, 0);
        do_req(2'b01, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 34, 0);
        // REMU on the cached unsigned key, held in DONE by STALL.
        do_req(2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 1);

        // Reset in the middle of WAIT.
        OP = 2'b01;
        RS1 = 32'd1000;
        RS2 = 32'd3;
        VALID_IN = 1'b1;
        @(posedge CLK);
        repeat (11) @(posedge CLK);
        #1;
        chk("busy_before_rst", BUSY, 1'b1);
        #2;
        RST_N = 1'b0;
        #1;
        chk("arst_busy", BUSY, 1'b0);
        chk("arst_valid", RESULT_VALID, 1'b0);
        chk("arst_result", RESULT, 32'h0);
        chk("arst_start", DIV_START, 1'b0);
        VALID_IN = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        chk("idle_after_rst", BUSY, 1'b0);

        // Cache was cleared: re-issue, then a hit on the refilled entry.
        do_req(2'b11, 32'd100, 32'd7, 32'd2, 34, 0);
        do_req(2'b01, 32'd100, 32'd7, 32'd14, 0, 0);

        repeat (3) @(posedge CLK);
        #1;
        chk("sb_drain", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/m_div_ctrl.md
# m_div_ctrl

Issue/control stage for the M-extension divide path. It accepts DIV/DIVU/REM/REMU requests from the execute stage and resolves RISC-V special cases (divide-by-zero, signed overflow) without using the divider. It also reuses the previous result when the operands repeat. For all other requests it converts operands to magnitudes, drives the iterative restoring divider unsigned, and applies the RISC-V sign rules to its outputs. It sits between the execute-stage operand latch and the divider, and returns one XLEN result per request to the writeback mux.

## Interface
- XLEN, 32, operand/result width; divider latency is XLEN+1 cycles after its START edge
- CLK  in  1  clock, all state on rising edge
- RST_N  in  1  asynchronous, active-low reset
- STALL  in  1  pipeline stall; blocks acceptance and holds a completed result
- VALID_IN  in  1  request present on OP/RS1/RS2
- OP  in  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
- RS1  in  XLEN  dividend
- RS2  in  XLEN  divisor
- BUSY  out  1  request in flight (ISSUE or WAIT); pipeline must stall on it
- RESULT_VALID  out  1  RESULT is valid (DONE state)
- RESULT  out  XLEN  quotient or remainder, selected by the accepted OP
- DIV_START  out  1  one-cycle start pulse to the divider
- DIV_SIGN  out  1  constant 0; the divider always runs unsigned
- DIV_STALL  out  1  constant 0
- DIV_DIVIDEND  out  XLEN  |RS1| (signed ops) or RS1, registered
- DIV_DIVIDER  out  XLEN  |RS2| (signed ops) or RS2, registered
- DIV_QUOTIENT  in  XLEN  divider quotient (unsigned magnitude)
- DIV_REMAINDER  in  XLEN  divider remainder (unsigned magnitude)
- DIV_READY  in  1  divider idle/complete

## Operation
- States: IDLE, ISSUE, WAIT, DONE. On reset: IDLE, all outputs 0, cache invalid, operand registers 0.
- Accept condition: state IDLE, VALID_IN=1 and STALL=0. On accept, latch OP, RS1, RS2, and signed = !OP[0].
- Classification at accept, in priority order:
  1. RS2==0 → DONE. Quotient = all ones; remainder = RS1.
  2. Signed op with RS1==1<<(XLEN-1) and RS2==all ones → DONE. Quotient = RS1; remainder = 0.
  3. Cache hit (cache valid, RS1, RS2 and signed all equal the cached key) → DONE with the cached quotient and remainder.
  4. Otherwise → ISSUE. Load DIV_DIVIDEND/DIV_DIVIDER with the magnitudes. Record negq = signed & (RS1[MSB]^RS2[MSB]) and negr = signed & RS1[MSB].
- Classes 1–3 never assert DIV_START.
- ISSUE: DIV_START=1 for exactly this cycle → WAIT.
- WAIT: when DIV_READY=1, capture the corrected results → DONE.
  - Quotient = negq ? -DIV_QUOTIENT : DIV_QUOTIENT.
  - Remainder = negr ? -DIV_REMAINDER : DIV_REMAINDER (two's complement, XLEN wrap).
  - Write key and results to the cache and set cache valid.
- Special-case results (classes 1–2) are not cached.
- DONE: RESULT_VALID=1. RESULT = OP[1] ? remainder : quotient.
  - STALL=1: stay in DONE with RESULT held.
  - STALL=0: → IDLE. No acceptance in this cycle.
- BUSY=1 exactly in ISSUE and WAIT.
- VALID_IN is ignored outside IDLE. The requester holds the request until it sees RESULT_VALID.
- Reset mid-operation:
  - Immediate return to IDLE; outputs 0; cache invalid.
  - The divider may keep counting. The next ISSUE pulse reloads it, and START overrides any iteration in progress.

## Timing
- Special case or cache hit: accept edge E0 → RESULT_VALID from E0+1 (1 cycle).
- Normal case, cycle by cycle:
  - E0: accept; state becomes ISSUE.
  - E1: divider samples DIV_START.
  - Divider READY goes high after E1+XLEN.
  - Capture at E1+XLEN+1, so RESULT_VALID rises XLEN+2 cycles after E0 (34 for XLEN=32).
- WAIT never sees a stale DIV_READY=1: the divider drops READY on the same edge it samples START.
- Minimum spacing between accepted requests: 2 cycles (DONE→IDLE→accept).

## Test plan
- DIV RS1=0x00000014, RS2=0xFFFFFFFD → RESULT 0xFFFFFFFA after 34 cycles, with one DIV_START pulse. Then REM on the same operands → 0x00000002 one cycle after accept, with no DIV_START.
- REM 7 / 0xFFFFFFFE → 0x00000001. REM 0xFFFFFFF9 / 2 → 0xFFFFFFFF. DIVU 100/7 → 14.
- DIVU 5/0 → 0xFFFFFFFF and REMU 5/0 → 5. Both have 1-cycle latency, DIV_START stays 0 and BUSY stays 0.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0. DIVU on the same operands uses the divider and returns 0x00000000.
- STALL held high for 5 cycles in DONE → RESULT_VALID and RESULT are stable throughout, and a VALID_IN pulse during that window is ignored. After STALL drops, the FSM returns to IDLE one cycle later.
- RST_N asserted in cycle 10 of WAIT → BUSY, RESULT_VALID and RESULT go to 0 asynchronously. A following REMU 100/7 misses the cache, re-issues and returns 2 after 34 cycles.
